// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants: prefix bytes, the key-event FSM states and
// the default game-key scancode table (key0=W, key1=S, key2=O, key3=L).
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam logic [31:0] DEFAULT_KEY_CODES = {8'h4B, 8'h44, 8'h1B, 8'h1D};

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } ps2_state_e;

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags; a push on a
// full FIFO succeeds when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Turns the PS/2 byte stream into press/release events for a table of game
// keys, keeps a live held-key bitmap and queues events for the consumer.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS   = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES  = (8*NUM_KEYS)'(DEFAULT_KEY_CODES),
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    TIMEOUT    = 65536,
  localparam int                   KW         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          code,
  input  logic                valid,
  output logic [NUM_KEYS-1:0] keyState,
  output logic                evValid,
  output logic [KW-1:0]       evKey,
  output logic                evPressed,
  input  logic                evReady,
  output logic                overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);

  ps2_state_e          state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic                last_valid_q;
  logic                overflow_q, overflow_d;

  logic                accept;
  logic                hit;
  logic [KW-1:0]       hit_idx;
  logic                push;
  logic                push_pressed;
  logic [KW:0]         head;
  logic                fifo_full, fifo_empty;
  logic                drop;

  assign accept = valid && !last_valid_q;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (code == KEY_CODES[8*i +: 8]) begin
        hit     = 1'b1;
        hit_idx = KW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    key_state_d  = key_state_q;
    push         = 1'b0;
    push_pressed = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (code == BREAK_CODE) begin
            state_d = BRK;
          end else if (code == EXT_CODE) begin
            state_d = EXT;
          end else if (hit && !key_state_q[hit_idx]) begin
            key_state_d[hit_idx] = 1'b1;
            push                 = 1'b1;
            push_pressed         = 1'b1;
          end
        end
        BRK: begin
          if (code != BREAK_CODE) begin
            state_d = IDLE;
            if (hit && key_state_q[hit_idx]) begin
              key_state_d[hit_idx] = 1'b0;
              push                 = 1'b1;
            end
          end
        end
        EXT:     state_d = (code == BREAK_CODE) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A stalled multi-byte sequence is abandoned so the next byte starts fresh.
      if (timer_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  assign drop       = push && fifo_full && !(evReady && !fifo_empty);
  assign overflow_d = overflow_q || drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      key_state_q  <= '0;
      last_valid_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      key_state_q  <= key_state_d;
      last_valid_q <= valid;
      overflow_q   <= overflow_d;
    end
  end

  event_fifo #(
    .WIDTH (KW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({hit_idx, push_pressed}),
    .pop       (evReady),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign keyState  = key_state_q;
  assign evValid   = !fifo_empty;
  assign evKey     = fifo_empty ? '0 : head[KW:1];
  assign evPressed = !fifo_empty && head[0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: a prefix/held-key/event-queue model
// is compared every cycle, plus hand-computed spot checks.
module tb_ps2_key_event_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 65536;

  logic       clk;
  logic       rst;
  logic [7:0] code;
  logic       valid;
  logic [3:0] key_state;
  logic       ev_valid;
  logic [1:0] ev_key;
  logic       ev_pressed;
  logic       ev_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ps2_key_event_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .code      (code),
    .valid     (valid),
    .keyState  (key_state),
    .evValid   (ev_valid),
    .evKey     (ev_key),
    .evPressed (ev_pressed),
    .evReady   (ev_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int key;
    bit pressed;
  } ev_t;

  logic [7:0] key_tab [4] = '{8'h1D, 8'h1B, 8'h44, 8'h4B};

  logic [3:0] m_held;
  bit         m_brk, m_ext, m_last_valid, m_ovf, m_started;
  int         m_wait;
  ev_t        m_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int keyIndex(input logic [7:0] b);
    for (int i = 0; i < 4; i++) begin
      if (key_tab[i] == b) return i;
    end
    return -1;
  endfunction

  // Model: prefix flags decide how a byte is read; events go through a queue.
  always @(posedge clk) begin
    int  k;
    bit  acc, have_ev;
    ev_t ev;
    if (rst) begin
      m_held = '0; m_brk = 0; m_ext = 0; m_wait = 0;
      m_last_valid = 1; m_ovf = 0; m_q.delete();
    end else begin
      have_ev = 0;
      acc = valid && !m_last_valid;
      m_last_valid = valid;
      if (acc) begin
        m_wait = 0;
        k = keyIndex(code);
        if (!m_ext && !m_brk) begin
          if (code == 8'hF0) m_brk = 1;
          else if (code == 8'hE0) m_ext = 1;
          else if (k >= 0 && !m_held[k]) begin
            m_held[k] = 1; ev = '{k, 1'b1}; have_ev = 1;
          end
        end else if (!m_ext) begin
          if (code != 8'hF0) begin
            m_brk = 0;
            if (k >= 0 && m_held[k]) begin
              m_held[k] = 0; ev = '{k, 1'b0}; have_ev = 1;
            end
          end
        end else if (!m_brk) begin
          if (code == 8'hF0) m_brk = 1; else m_ext = 0;
        end else begin
          m_ext = 0; m_brk = 0;
        end
      end else if (m_ext || m_brk) begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_ext = 0; m_brk = 0; m_wait = 0;
        end
      end
      if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
      if (have_ev) begin
        if (m_q.size() < DEPTH) m_q.push_back(ev);
        else m_ovf = 1;
      end
    end
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      checkOutput("keyState", key_state, m_held);
      checkOutput("evValid", ev_valid, m_q.size() > 0);
      checkOutput("overflow", overflow, m_ovf);
      if (m_q.size() > 0) begin
        checkOutput("evKey", ev_key, m_q[0].key);
        checkOutput("evPressed", ev_pressed, m_q[0].pressed);
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendByteNoTail(input logic [7:0] b);
    code  = b;
    valid = 1'b1;
    stepCycles(1);
    valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    sendByteNoTail(b);
    stepCycles(1);
  endtask

  task automatic popOne();
    ev_ready = 1'b1;
    stepCycles(1);
    ev_ready = 1'b0;
  endtask

  initial begin
    m_started = 0;
    rst = 1'b1; valid = 1'b0; code = 8'h00; ev_ready = 1'b0;
    stepCycles(2);
    checkOutput("rst_keyState", key_state, 4'b0000);
    checkOutput("rst_evValid", ev_valid, 1'b0);
    checkOutput("rst_evKey", ev_key, 2'd0);
    checkOutput("rst_evPressed", ev_pressed, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    stepCycles(1);

    $display("[TB] make/break of key0");
    sendByteNoTail(8'h1D);
    checkOutput("t1_make_valid", ev_valid, 1'b1);
    checkOutput("t1_make_key", ev_key, 2'd0);
    checkOutput("t1_make_pressed", ev_pressed, 1'b1);
    checkOutput("t1_make_state", key_state, 4'b0001);
    popOne();
    checkOutput("t1_pop_empty", ev_valid, 1'b0);
    applyStimulus(8'hF0);
    sendByteNoTail(8'h1D);
    checkOutput("t1_brk_valid", ev_valid, 1'b1);
    checkOutput("t1_brk_pressed", ev_pressed, 1'b0);
    checkOutput("t1_brk_state", key_state, 4'b0000);
    popOne();

    $display("[TB] typematic repeat");
    repeat (3) applyStimulus(8'h1B);
    checkOutput("t2_state", key_state, 4'b0010);
    checkOutput("t2_key", ev_key, 2'd1);
    popOne();
    checkOutput("t2_single_event", ev_valid, 1'b0);
    applyStimulus(8'hF0);
    applyStimulus(8'h1B);
    popOne();

    $display("[TB] extended sequences");
    applyStimulus(8'hE0); applyStimulus(8'h1D);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h1D);
    checkOutput("t3_ext_noevent", ev_valid, 1'b0);
    checkOutput("t3_ext_state", key_state, 4'b0000);
    applyStimulus(8'h1D);
    popOne();
    applyStimulus(8'hF0); applyStimulus(8'hE0); applyStimulus(8'h1D);
    checkOutput("t3_f0e0_noevent", ev_valid, 1'b0);
    checkOutput("t3_f0e0_state", key_state, 4'b0001);
    applyStimulus(8'hF0); applyStimulus(8'h1D);
    checkOutput("t3_idle_brk_pressed", ev_pressed, 1'b0);
    checkOutput("t3_idle_brk_state", key_state, 4'b0000);
    popOne();

    $display("[TB] prefix timeout");
    applyStimulus(8'hF0);
    stepCycles(TIMEOUT + 4);
    applyStimulus(8'h1D);
    checkOutput("t4_timeout_valid", ev_valid, 1'b1);
    checkOutput("t4_timeout_make", ev_pressed, 1'b1);
    popOne();
    applyStimulus(8'hF0);
    stepCycles(100);
    applyStimulus(8'h1D);
    checkOutput("t4_short_wait_brk", ev_pressed, 1'b0);
    popOne();

    $display("[TB] overflow and full push with pop");
    applyStimulus(8'h1D); applyStimulus(8'h1B);
    applyStimulus(8'h44); applyStimulus(8'h4B);
    applyStimulus(8'hF0); applyStimulus(8'h1D);
    checkOutput("t5_overflow", overflow, 1'b1);
    checkOutput("t5_state", key_state, 4'b1110);
    checkOutput("t5_head_key", ev_key, 2'd0);
    checkOutput("t5_head_pressed", ev_pressed, 1'b1);
    applyStimulus(8'hF0);
    ev_ready = 1'b1;
    sendByteNoTail(8'h1B);
    ev_ready = 1'b0;
    checkOutput("t5_pushpop_state", key_state, 4'b1100);
    checkOutput("t5_pushpop_head", ev_key, 2'd1);
    ev_ready = 1'b1;
    stepCycles(3);
    checkOutput("t5_tail_key", ev_key, 2'd1);
    checkOutput("t5_tail_pressed", ev_pressed, 1'b0);
    stepCycles(1);
    ev_ready = 1'b0;
    checkOutput("t5_drained", ev_valid, 1'b0);

    $display("[TB] reset behaviour");
    rst = 1'b1; code = 8'h1D; valid = 1'b1;
    stepCycles(2);
    rst = 1'b0;
    stepCycles(2);
    checkOutput("t6_held_valid_noevent", ev_valid, 1'b0);
    checkOutput("t6_held_valid_state", key_state, 4'b0000);
    checkOutput("t6_overflow_cleared", overflow, 1'b0);
    valid = 1'b0;
    stepCycles(1);
    applyStimulus(8'hF0);
    rst = 1'b1;
    sendByteNoTail(8'h1D);
    stepCycles(1);
    rst = 1'b0;
    stepCycles(1);
    checkOutput("t6_mid_keyState", key_state, 4'b0000);
    checkOutput("t6_mid_evValid", ev_valid, 1'b0);
    checkOutput("t6_mid_evKey", ev_key, 2'd0);
    checkOutput("t6_mid_evPressed", ev_pressed, 1'b0);
    checkOutput("t6_mid_overflow", overflow, 1'b0);
    applyStimulus(8'h1D);
    checkOutput("t6_after_make", key_state, 4'b0001);
    stepCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequences the decoded PS/2 byte stream (`code`/`valid` from the `PS2` receiver) into per-key press/release events for a configurable table of game keys. It tracks make, break and extended prefixes with a timeout-guarded FSM, and maintains a live pressed-key bitmap. Events are queued in a small FIFO with a ready/valid handshake so game logic (paddles, menus, pause) can consume them at its own pace. It sits between `PS2` and every keyboard consumer.

## Interface
- `NUM_KEYS`, 4: number of tracked keys, 1..8.
- `KEY_CODES`, {8'h4B,8'h44,8'h1B,8'h1D}: packed scancodes; byte i (bits 8i+7:8i) is key i; default key0=W, key1=S, key2=O, key3=L.
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of 2, ≥2.
- `TIMEOUT`, 65536: clk cycles allowed between bytes of a multi-byte sequence.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `code` in 8: byte from `PS2`.
- `valid` in 1: level from `PS2`; held high for ≥1 cycle per byte.
- `keyState` out NUM_KEYS: bit i is 1 while key i is held.
- `evValid` out 1: FIFO head holds an event.
- `evKey` out $clog2(NUM_KEYS) (min 1): key index of the head event.
- `evPressed` out 1: 1 = press, 0 = release.
- `evReady` in 1: consumer accepts the head event.
- `overflow` out 1: sticky; set when an event is dropped on a full FIFO.

## Operation
- Byte acceptance: a byte is accepted in the cycle where `valid`=1 and the registered previous `valid` (`lastValid`) is 0. Exactly one acceptance per `valid` pulse.
- FSM states: IDLE, BRK, EXT, EXT_BRK. The FSM only changes on an accepted byte or on timeout.
  - IDLE: F0 → BRK. E0 → EXT. A byte matching key i is a make (stay IDLE). Any other byte is ignored.
  - BRK: F0 → BRK (restart). A byte matching key i is a break, then → IDLE. Any other byte, including E0, → IDLE with no event.
  - EXT: F0 → EXT_BRK. Any other byte → IDLE. Extended makes are discarded.
  - EXT_BRK: any byte → IDLE. Extended breaks are discarded, even if the byte matches the table.
- Key matching: lowest index wins if `KEY_CODES` contains duplicates.
- Make of key i: if `keyState[i]`=0, set it and push {i,1}. If already held (typematic repeat), do nothing.
- Break of key i: if `keyState[i]`=1, clear it and push {i,0}. Otherwise do nothing.
- Timeout counter:
  - Cleared on every accepted byte and whenever the FSM is in IDLE.
  - Increments while the FSM is not in IDLE.
  - When it reaches TIMEOUT-1, the FSM → IDLE and the counter clears.
- FIFO behaviour:
  - First-word fall-through: `evValid` = not empty, and `evKey`/`evPressed` show the head entry.
  - Pop on `evValid && evReady`. `evReady` while empty has no effect.
  - Push while full with a pop in the same cycle succeeds.
  - Push while full without a pop drops the event and sets `overflow`. `keyState` still updates.
- `overflow` clears only on `rst`.

## Timing
- Reset values: `keyState`=0, `evValid`=0, `evKey`=0, `evPressed`=0, `overflow`=0. FSM=IDLE, counter=0, FIFO empty.
- `lastValid` resets to 1, so a `valid` held high across reset release is not accepted.
- Latency: a byte accepted in cycle n updates `keyState` and pushes its event at the clock edge ending cycle n. `evValid` is high in cycle n+1 if the FIFO was empty.
- Pop takes effect at the clock edge. The next head, or `evValid`=0, is visible the following cycle.
- Reset asserted mid-sequence discards the partial sequence, the FIFO contents and all held keys. No release events are generated.
- Throughput: one accepted byte per cycle at most, so at most one push per cycle.

## Structure
- Package `ps2_pkg`: `BREAK_CODE`=8'hF0, `EXT_CODE`=8'hE0, FSM state enum, default `KEY_CODES` constant. `PS2` and paddle logic share these.
- Sub-module `event_fifo`: synchronous FWFT FIFO, parameterised by width and depth, with full/empty and simultaneous push/pop support.
- Top level holds the edge detect, FSM, key match, timeout counter and `keyState`.

## Test plan
- Defaults. Byte 1D, then F0 then 1D → `keyState[0]` goes 1 then 0. Events {0,1} then {0,0}, each with `evValid` 1 cycle after acceptance.
- Byte 1B sent 3× (typematic) → exactly one event {1,1}. `keyState`=4'b0010.
- E0 1D, then E0 F0 1D → no events, `keyState` unchanged. F0 E0 1D → no event, FSM back in IDLE.
- F0, then no bytes for 65536 cycles, then 1D → treated as a make: event {0,1}.
- `evReady`=0. Send makes for keys 0,1,2,3 and then a 5th event (break of key 0 via F0 1D) → FIFO holds 4 events, `overflow`=1, `keyState[0]`=0. Full push with simultaneous pop → no drop.
- `valid` held high through a `rst` pulse with code 1D → no event after reset. Assert `rst` between F0 and 1D → no event, all outputs at reset values.
